cmd_deserializer: RTL

Receive-side counterpart of the SD host command-line serializer. It watches the serial CMD line and detects the start bit of a card response. It shifts in a fixed-width frame MSB first and checks the end bit and, optionally, CRC7. It then presents the parallel frame to the command controller with a one-cycle valid pulse, and raises a timeout if no response starts within a bounded window.

---
 rtl/cmd_deserializer.sv | 104 ++++++++++
 1 files changed

// File: rtl/cmd_deserializer.sv
// cmd_deserializer: receives one SD CMD-line response frame per enable, with end-bit, optional CRC7 and start timeout checks
// Parameters: WIDTH frame bits (>=16), TIMEOUT idle-high samples tolerated before timeout (>=2)
// Ports: clk, reset (sync, active-low), enable (level arm), in (serial CMD line),
//        out (last frame, first bit in MSB), valid (1-cycle), busy, frame_err, crc_err, timeout (1-cycle)
// Define CMD_CRC_CHECK_EN to build the CRC7 checker; otherwise crc_err is tied to 0.
module cmd_deserializer #(
    parameter int WIDTH   = 48,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             frame_err,
    output logic             crc_err,
    output logic             timeout
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST     = BW'(WIDTH - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, WAIT_START, SHIFT, HOLD} state_t;
    state_t state, state_nx;
    logic [BW-1:0] bit_cnt;
    logic [IW-1:0] idle_cnt;
    // Holds every bit after the start bit; the end bit is taken straight from the line.
    logic [WIDTH-2:0] sreg;
    logic start, done, expire;
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = !enable             ? IDLE :
                   state == IDLE       ? WAIT_START :
                   start               ? SHIFT :
                   (expire || done)    ? HOLD : state;
    end
    always_comb begin
        start  = enable && state == WAIT_START && !in;
        expire = enable && state == WAIT_START && in && idle_cnt == IDLE_MAX;
        done   = enable && state == SHIFT && bit_cnt == LAST;
        busy   = state == WAIT_START || state == SHIFT;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            sreg      <= '0;
            out       <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid   <= done;
            timeout <= expire;
            if (state == IDLE) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end
            if (state == WAIT_START && in)
                idle_cnt <= idle_cnt + 1'b1;
            if (start) begin
                bit_cnt <= BW'(1);
                sreg    <= '0;
            end
            if (state == SHIFT) begin
                bit_cnt <= bit_cnt + 1'b1;
                sreg    <= {sreg[WIDTH-3:0], in};
            end
            if (done) begin
                out       <= {sreg, in};
                frame_err <= !in;
            end
        end
    end
`ifdef CMD_CRC_CHECK_EN
    localparam logic [BW-1:0] CRC_END = BW'(WIDTH - 8);
    logic [6:0] crc;
    logic       fb;
    assign fb = crc[6] ^ in;
    // The start bit is 0, so a zero-initialised CRC is unchanged by it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            crc     <= '0;
            crc_err <= 1'b0;
        end else begin
            if (state == WAIT_START)
                crc <= '0;
            else if (state == SHIFT && bit_cnt < CRC_END)
                crc <= {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
            if (done)
                crc_err <= crc != sreg[6:0];
        end
    end
`else
    assign crc_err = 1'b0;
`endif
endmodule
